player_cursor_arbiter: RTL
==========================

Name: player_cursor_arbiter

Overview:
- Shares one on-screen character cursor between player 1 and player 2 d-pad switch banks.
- Once per video frame, at the start of vertical blanking, it grants one requester by round-robin. It then applies that player's move or home command and publishes the new cursor position.
- The position feeds the show_one_char CHAR_X/CHAR_Y location inputs.
- Sits between the switch inputs, hvsync_generator hpos/vpos, and the character renderer.

Parameters:
- H_ACTIVE, 256, visible pixels per line.
- V_ACTIVE, 240, visible lines per frame.
- CHAR_W, 48, cursor glyph width in pixels (8 cells x 6-pixel scale).
- CHAR_H, 48, cursor glyph height in pixels.
- STEP, 2, pixels moved per granted frame per axis.
- INIT_X, 64, home/reset X position.
- INIT_Y, 30, home/reset Y position.

Ports:
- clk  in  1  system/pixel clock
- reset  in  1  synchronous, active-high reset
- hpos  in  9  current horizontal pixel position from hvsync_generator
- vpos  in  9  current vertical line position from hvsync_generator
- p1_dir  in  5  player 1 switches {fire, down, up, right, left}
- p2_dir  in  5  player 2 switches, same bit order as p1_dir
- char_x  out  9  cursor X position
- char_y  out  9  cursor Y position
- owner  out  1  player of the most recent grant (0 = P1, 1 = P2)
- busy  out  1  high while the FSM is not in IDLE
- moved  out  1  one-cycle pulse when char_x or char_y changed

Behaviour:
- Reset values (one clock only; synchronous, active-high):
  - char_x = INIT_X, char_y = INIT_Y.
  - owner = 0, busy = 0, moved = 0.
  - FSM = IDLE, last_grant = 1, so P1 wins the first contention.
- Frame tick: frame_start is a registered one-cycle pulse in the cycle after (vpos == V_ACTIVE && hpos == 0) is first seen. It fires once per frame.
- Requests: a player requests when any bit of its dir input is 1.
- FSM, one state per clock: IDLE -> ARB -> MOVE -> IDLE.
- IDLE:
  - busy = 0.
  - On frame_start, go to ARB.
- ARB:
  - Sample p1_dir and p2_dir into internal latches; later switch changes are ignored this frame.
  - Both players request: grant !last_grant.
  - One player requests: grant that player.
  - Neither requests: return to IDLE; owner and last_grant are unchanged.
  - On a grant: owner <= granted player, last_grant <= granted player, go to MOVE.
- MOVE, using the granted player's latched bits:
  - fire = 1: position <= (INIT_X, INIT_Y). Fire has priority over all direction bits.
  - X axis: left only gives x - STEP; right only gives x + STEP; left and right together, or neither, gives no X change.
  - Y axis: up only gives y - STEP; down only gives y + STEP; up and down together gives no Y change.
  - X and Y update in the same cycle.
  - Arithmetic uses 10-bit signed intermediates.
  - Result is bounded to X in [0, H_ACTIVE-CHAR_W] = [0, 208] and Y in [0, V_ACTIVE-CHAR_H] = [0, 192]. The clamp/wrap rule is set by the Optional Feature.
  - Registered position updates at the MOVE->IDLE edge; go to IDLE.
- moved:
  - Asserted for exactly the one cycle after MOVE, and only if char_x or char_y differs from its pre-MOVE value.
  - A clamped no-op or a home command while already at home gives moved = 0.
- Latency: char_x/char_y are valid 3 clocks after the frame_start pulse cycle.
- A second frame_start cannot arrive while busy, because frames are far longer than 3 cycles. A frame_start that does arrive outside IDLE is ignored.
- Reset in any state aborts the operation:
  - No pending position update is applied.
  - All outputs return to reset values on the next edge.

Optional Feature:
- Macro: CURSOR_WRAP_EN.
- Defined: out-of-range results wrap to the opposite bound. Below 0 gives the max bound (208 or 192). Above the max bound gives 0.
- Undefined: results saturate at 0 and at the max bound.
- Home/fire behaviour is the same in both builds.

Test Plan:
- Reset, then idle frames with no switches pressed -> char_x = 64, char_y = 30, owner = 0, busy = 0, moved never pulses.
- p1_dir = 5'b00010 (right) held for 3 frames -> char_x = 66, 68, 70; char_y = 30; owner = 0; one moved pulse per frame, 3 clocks after frame_start.
- p1_dir = right and p2_dir = 5'b01000 (down) both held for 4 frames -> grants alternate P1, P2, P1, P2 (owner 0, 1, 0, 1); final position (68, 34).
- Start at char_x = 206, P1 right held for 2 frames:
  - Default build: char_x = 208 then 208, second frame moved = 0.
  - With CURSOR_WRAP_EN: 208 then 0.
- Start at (100, 100), P2 asserts fire + left -> position (64, 30), owner = 1, moved pulses.
- Assert reset in the MOVE cycle of a P1 right move from (64, 30) -> position stays (64, 30), busy = 0, moved = 0; the next P1-only frame grants P1.

Source files
------------

// File: rtl/player_cursor_arbiter_if.sv
// Signal bundle between the video timing / switch inputs and the cursor arbiter.
// The slave modport is the arbiter's view; master is the driver/consumer side.
interface player_cursor_arbiter_if;
    logic [8:0] hpos;
    logic [8:0] vpos;
    logic [4:0] p1_dir;
    logic [4:0] p2_dir;
    logic [8:0] char_x;
    logic [8:0] char_y;
    logic       owner;
    logic       busy;
    logic       moved;

    modport master (
        output hpos, vpos, p1_dir, p2_dir,
        input  char_x, char_y, owner, busy, moved
    );

    modport slave (
        input  hpos, vpos, p1_dir, p2_dir,
        output char_x, char_y, owner, busy, moved
    );
endinterface

// File: rtl/player_cursor_arbiter.sv
// Once-per-frame round-robin arbiter sharing a character cursor between two d-pads.
// Define CURSOR_WRAP_EN to wrap out-of-range moves instead of saturating them.
module player_cursor_arbiter #(
    parameter int H_ACTIVE = 256,
    parameter int V_ACTIVE = 240,
    parameter int CHAR_W   = 48,
    parameter int CHAR_H   = 48,
    parameter int STEP     = 2,
    parameter int INIT_X   = 64,
    parameter int INIT_Y   = 30
) (
    input  logic                    clk,
    input  logic                    reset,
    player_cursor_arbiter_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARB  = 2'd1;
    localparam logic [1:0] S_MOVE = 2'd2;

    localparam logic signed [9:0] X_MAX  = 10'(H_ACTIVE - CHAR_W);
    localparam logic signed [9:0] Y_MAX  = 10'(V_ACTIVE - CHAR_H);
    localparam logic signed [9:0] STEP_S = 10'(STEP);
    localparam logic [8:0]        HOME_X = 9'(INIT_X);
    localparam logic [8:0]        HOME_Y = 9'(INIT_Y);

    // Brings an out-of-range coordinate back inside [0, vmax].
    function automatic logic [8:0] fit(input logic signed [9:0] v, input logic signed [9:0] vmax);
        logic signed [9:0] r;
`ifdef CURSOR_WRAP_EN
        if (v < 10'sd0) begin
            r = vmax;
        end else if (v > vmax) begin
            r = 10'sd0;
        end else begin
            r = v;
        end
`else
        if (v < 10'sd0) begin
            r = 10'sd0;
        end else if (v > vmax) begin
            r = vmax;
        end else begin
            r = v;
        end
`endif
        return 9'(r);
    endfunction

    logic [1:0] state_q, state_d;
    logic       seen_q, seen_d;
    logic       frame_start_q, frame_start_d;
    logic [4:0] p1_lat_q, p1_lat_d;
    logic [4:0] p2_lat_q, p2_lat_d;
    logic       owner_q, owner_d;
    logic       last_grant_q, last_grant_d;
    logic [8:0] char_x_q, char_x_d;
    logic [8:0] char_y_q, char_y_d;
    logic       busy_q, busy_d;
    logic       moved_q, moved_d;

    logic              tick_s;
    logic              req1_s, req2_s, grant_s;
    logic [4:0]        sel_s;
    logic signed [9:0] dx_s, dy_s, nx_s, ny_s;
    logic [8:0]        x_new_s, y_new_s;

    // Start-of-vblank detection: pulse once on the first cycle the position is seen.
    always_comb begin
        tick_s        = (bus.vpos == 9'(V_ACTIVE)) && (bus.hpos == 9'd0);
        seen_d        = tick_s;
        frame_start_d = tick_s && !seen_q;
    end

    // Move target computed from the granted player's latched switches.
    always_comb begin
        sel_s = owner_q ? p2_lat_q : p1_lat_q;
        case (sel_s[1:0])
            2'b01:   dx_s = -STEP_S;
            2'b10:   dx_s = STEP_S;
            default: dx_s = 10'sd0;
        endcase
        case (sel_s[3:2])
            2'b01:   dy_s = -STEP_S;
            2'b10:   dy_s = STEP_S;
            default: dy_s = 10'sd0;
        endcase
        nx_s = $signed({1'b0, char_x_q}) + dx_s;
        ny_s = $signed({1'b0, char_y_q}) + dy_s;
        if (sel_s[4]) begin
            x_new_s = HOME_X;
            y_new_s = HOME_Y;
        end else begin
            x_new_s = fit(nx_s, X_MAX);
            y_new_s = fit(ny_s, Y_MAX);
        end
    end

    // Arbitration FSM next-state and output logic.
    always_comb begin
        state_d      = state_q;
        p1_lat_d     = p1_lat_q;
        p2_lat_d     = p2_lat_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        char_x_d     = char_x_q;
        char_y_d     = char_y_q;
        moved_d      = 1'b0;
        req1_s       = |bus.p1_dir;
        req2_s       = |bus.p2_dir;
        if (req1_s && req2_s) begin
            grant_s = ~last_grant_q;
        end else if (req2_s) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        case (state_q)
            S_IDLE: begin
                if (frame_start_q) begin
                    state_d = S_ARB;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ARB: begin
                p1_lat_d = bus.p1_dir;
                p2_lat_d = bus.p2_dir;
                if (req1_s || req2_s) begin
                    owner_d      = grant_s;
                    last_grant_d = grant_s;
                    state_d      = S_MOVE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MOVE: begin
                char_x_d = x_new_s;
                char_y_d = y_new_s;
                moved_d  = (x_new_s != char_x_q) || (y_new_s != char_y_q);
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset drops any in-flight move.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            seen_q        <= 1'b0;
            frame_start_q <= 1'b0;
            p1_lat_q      <= 5'd0;
            p2_lat_q      <= 5'd0;
            owner_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            char_x_q      <= HOME_X;
            char_y_q      <= HOME_Y;
            busy_q        <= 1'b0;
            moved_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            seen_q        <= seen_d;
            frame_start_q <= frame_start_d;
            p1_lat_q      <= p1_lat_d;
            p2_lat_q      <= p2_lat_d;
            owner_q       <= owner_d;
            last_grant_q  <= last_grant_d;
            char_x_q      <= char_x_d;
            char_y_q      <= char_y_d;
            busy_q        <= busy_d;
            moved_q       <= moved_d;
        end
    end

    assign bus.char_x = char_x_q;
    assign bus.char_y = char_y_q;
    assign bus.owner  = owner_q;
    assign bus.busy   = busy_q;
    assign bus.moved  = moved_q;

endmodule
